// File: rtl/sobel_mag_sqrt_feed_pkg.sv
// Shared video-stage types: pixel width, packed sync bundle and an 8-bit saturator.
// Used by every stage of the edge-detection path.
package sobel_mag_sqrt_feed_pkg;

   localparam int PIX_W  = 8;
   localparam int SYNC_W = 3;

   typedef struct packed {
      logic vsync;
      logic hsync;
      logic de;
   } sync_t;

   // Clamp an unsigned value to the 8-bit pixel range.
   function automatic logic [PIX_W-1:0] sat_pix(input logic [63:0] v);
      return (v > 64'd255) ? 8'hFF : v[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_mag_sqrt_feed_if.sv
// Gradient-in / magnitude-out bundle, including the rom_sqrt address/data pair.
// The master side is the Sobel stage plus the ROM; the slave side is the magnitude block.
interface sobel_mag_sqrt_feed_if
   import sobel_mag_sqrt_feed_pkg::*;
#(
   parameter int G_W = 11
);

   logic                    in_vsync;
   logic                    in_hsync;
   logic                    in_de;
   logic signed [G_W-1:0]   in_gx;
   logic signed [G_W-1:0]   in_gy;
   logic [PIX_W-1:0]        thresh;

   logic [PIX_W-1:0]        rom_addr;
   logic [PIX_W-1:0]        rom_data;

   logic                    out_vsync;
   logic                    out_hsync;
   logic                    out_de;
   logic [PIX_W-1:0]        out_mag;
   logic                    out_edge;

   modport master (
      output in_vsync, in_hsync, in_de, in_gx, in_gy, thresh, rom_data,
      input  rom_addr, out_vsync, out_hsync, out_de, out_mag, out_edge
   );

   modport slave (
      input  in_vsync, in_hsync, in_de, in_gx, in_gy, thresh, rom_data,
      output rom_addr, out_vsync, out_hsync, out_de, out_mag, out_edge
   );

endinterface

// File: rtl/sobel_mag_sqrt_feed_sync_delay.sv
// Reusable W-bit sync shift register, DEPTH clocks, async active-low clear.
// Free-running; no handshake.
module sobel_mag_sqrt_feed_sync_delay #(
   parameter int W     = 3,
   parameter int DEPTH = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr[i] <= '0;
         end
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/sobel_mag_sqrt_feed.sv
// Gradient magnitude via external sqrt ROM: sat((gx^2+gy^2)>>SHIFT) -> rom_sqrt -> mag + edge bit.
// Latency 3+ROM_LAT clocks, one pixel per clock, no back-pressure.
module sobel_mag_sqrt_feed
   import sobel_mag_sqrt_feed_pkg::*;
#(
   parameter int G_W     = 11,
   parameter int SHIFT   = 8,
   parameter int ROM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sobel_mag_sqrt_feed_if.slave  bus
);

   localparam int SQ_W       = 2*G_W - 1;
   localparam int SUM_W      = 2*G_W;
   // Syncs go through SYNC_DEPTH stages here, then the S4 output flop.
   localparam int SYNC_DEPTH = 2 + ROM_LAT;

   // ---------------- S1: squares ----------------
   // Sign-extending to the product width keeps (-2^(G_W-1))^2 exact.
   logic signed [SQ_W-1:0] gx_w;
   logic signed [SQ_W-1:0] gy_w;
   logic signed [SQ_W-1:0] px;
   logic signed [SQ_W-1:0] py;
   logic        [SQ_W-1:0] sq_x;
   logic        [SQ_W-1:0] sq_y;

   assign gx_w = {{(SQ_W-G_W){bus.in_gx[G_W-1]}}, bus.in_gx};
   assign gy_w = {{(SQ_W-G_W){bus.in_gy[G_W-1]}}, bus.in_gy};
   assign px   = gx_w * gx_w;
   assign py   = gy_w * gy_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_x <= '0;
         sq_y <= '0;
      end else begin
         sq_x <= bus.in_de ? $unsigned(px) : '0;
         sq_y <= bus.in_de ? $unsigned(py) : '0;
      end
   end

   // ---------------- S2: sum, scale, saturate -> ROM address ----------------
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] scaled;
   logic [PIX_W-1:0] addr_q;

   assign sum    = {1'b0, sq_x} + {1'b0, sq_y};
   assign scaled = sum >> SHIFT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else begin
         addr_q <= sat_pix(64'(scaled));
      end
   end

   assign bus.rom_addr = addr_q;

   // ---------------- Sync delay, aligned with rom_data ----------------
   sync_t sync_in;
   sync_t sync_d;

   assign sync_in = {bus.in_vsync, bus.in_hsync, bus.in_de};

   sobel_mag_sqrt_feed_sync_delay #(
      .W     (SYNC_W),
      .DEPTH (SYNC_DEPTH)
   ) u_sync_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sync_in),
      .q     (sync_d)
   );

   // ---------------- S4: capture ROM data, threshold ----------------
   logic             vsync_q;
   logic             hsync_q;
   logic             de_q;
   logic [PIX_W-1:0] mag_q;
   logic             edge_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q <= 1'b0;
         hsync_q <= 1'b0;
         de_q    <= 1'b0;
         mag_q   <= '0;
         edge_q  <= 1'b0;
      end else begin
         vsync_q <= sync_d.vsync;
         hsync_q <= sync_d.hsync;
         de_q    <= sync_d.de;
         mag_q   <= sync_d.de ? bus.rom_data : '0;
         edge_q  <= sync_d.de & (bus.rom_data >= bus.thresh);
      end
   end

   assign bus.out_vsync = vsync_q;
   assign bus.out_hsync = hsync_q;
   assign bus.out_de    = de_q;
   assign bus.out_mag   = mag_q;
   assign bus.out_edge  = edge_q;

endmodule

// File: tb/tb_sobel_mag_sqrt_feed.sv
// Bench for sobel_mag_sqrt_feed: behavioural rom_sqrt, directed corner pixels plus random traffic,
// expected outputs queued at drive time and compared by an independent monitor.
module tb_sobel_mag_sqrt_feed;
   import sobel_mag_sqrt_feed_pkg::*;

   localparam int G_W     = 11;
   localparam int SHIFT   = 8;
   localparam int ROM_LAT = 1;
   localparam int LAT     = 3 + ROM_LAT;
   localparam int ADDR_LAT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sobel_mag_sqrt_feed_if #(.G_W(G_W)) bus ();

   sobel_mag_sqrt_feed #(
      .G_W     (G_W),
      .SHIFT   (SHIFT),
      .ROM_LAT (ROM_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Behavioural rom_sqrt: round(16*sqrt(a)) capped at 255, one clock read latency.
   int rom_tab [256];
   initial begin
      for (int a = 0; a < 256; a++) begin
         int v;
         v = $rtoi(16.0 * $sqrt(real'(a)) + 0.5);
         rom_tab[a] = (v > 255) ? 255 : v;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.rom_data <= '0;
      else        bus.rom_data <= 8'(rom_tab[bus.rom_addr]);
   end

   typedef struct {
      bit vs;
      bit hs;
      bit de;
      int mag;
      bit edg;
   } want_t;

   want_t oq [$];
   int    aq [$];
   int    checks = 0;
   int    passed = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got == want) passed++;
      else $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
   endtask

   function automatic int model_addr(input int gx, input int gy, input bit de);
      int s;
      if (!de) return 0;
      s = (gx*gx + gy*gy) / (1 << SHIFT);
      return (s > 255) ? 255 : s;
   endfunction

   // Apply one pixel and queue what must come out LAT (and ADDR_LAT) clocks later.
   task automatic drive(input bit vs, input bit hs, input bit de, input int gx, input int gy);
      want_t w;
      int    a;
      bus.in_vsync = vs;
      bus.in_hsync = hs;
      bus.in_de    = de;
      bus.in_gx    = gx[G_W-1:0];
      bus.in_gy    = gy[G_W-1:0];
      a     = model_addr(gx, gy, de);
      w.vs  = vs;
      w.hs  = hs;
      w.de  = de;
      w.mag = de ? rom_tab[a] : 0;
      w.edg = de && (w.mag >= int'(bus.thresh));
      aq.push_back(a);
      oq.push_back(w);
   endtask

   task automatic tick(input bit vs, input bit hs, input bit de, input int gx, input int gy);
      @(posedge clk);
      #1;
      drive(vs, hs, de, gx, gy);
   endtask

   // Release reset just after an edge; the pipeline owes zeros until the first pixel arrives.
   task automatic release_reset();
      want_t z;
      z = '{vs: 1'b0, hs: 1'b0, de: 1'b0, mag: 0, edg: 1'b0};
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (LAT)      oq.push_back(z);
      repeat (ADDR_LAT) aq.push_back(0);
   endtask

   // Thresh only moves during vsync with no pixels in flight.
   task automatic set_thresh(input int t);
      repeat (LAT) tick(1'b1, 1'b0, 1'b0, 0, 0);
      @(posedge clk);
      #1;
      bus.thresh = t[PIX_W-1:0];
      drive(1'b1, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_vsync"}, int'(bus.out_vsync), 0);
      chk({tag, "_hsync"}, int'(bus.out_hsync), 0);
      chk({tag, "_de"},    int'(bus.out_de),    0);
      chk({tag, "_mag"},   int'(bus.out_mag),   0);
      chk({tag, "_edge"},  int'(bus.out_edge),  0);
      chk({tag, "_addr"},  int'(bus.rom_addr),  0);
   endtask

   task automatic random_px(input int n, input int de_pct);
      for (int i = 0; i < n; i++) begin
         tick(bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 7) == 0),
              bit'($urandom_range(1, 100) <= de_pct),
              int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024);
      end
   endtask

   // Monitor: one expected entry per clock while out of reset.
   want_t mw;
   int    ma;
   always @(negedge clk) begin
      if (rst_n) begin
         if (oq.size() > 0) begin
            mw = oq.pop_front();
            chk("out_vsync", int'(bus.out_vsync), int'(mw.vs));
            chk("out_hsync", int'(bus.out_hsync), int'(mw.hs));
            chk("out_de",    int'(bus.out_de),    int'(mw.de));
            chk("out_mag",   int'(bus.out_mag),   mw.mag);
            chk("out_edge",  int'(bus.out_edge),  int'(mw.edg));
         end
         if (aq.size() > 0) begin
            ma = aq.pop_front();
            chk("rom_addr", int'(bus.rom_addr), ma);
         end
      end
   end

   initial begin
      bus.in_vsync = 1'b0;
      bus.in_hsync = 1'b0;
      bus.in_de    = 1'b0;
      bus.in_gx    = '0;
      bus.in_gy    = '0;
      bus.thresh   = 8'd200;

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");

      release_reset();
      drive(1'b0, 1'b0, 1'b0, 0, 0);

      // Directed corners: vsync edge, isolated de/hsync pulse, sign symmetry, saturation, gaps.
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      tick(1'b1, 1'b1, 1'b1, 160, 120);
      tick(1'b1, 1'b0, 1'b0, 500, 0);
      tick(1'b0, 1'b0, 1'b1, -160, -120);
      tick(1'b0, 1'b0, 1'b1, -1024, 0);
      tick(1'b0, 1'b0, 1'b1, 0, -1024);
      tick(1'b0, 1'b0, 1'b1, 255, 16);
      tick(1'b0, 1'b0, 1'b1, 256, 0);
      tick(1'b0, 1'b0, 1'b1, 0, 0);
      tick(1'b0, 1'b0, 1'b1, 150, 120);
      tick(1'b0, 1'b1, 1'b0, 500, 500);
      tick(1'b0, 1'b0, 1'b1, 1023, -1024);
      tick(1'b0, 1'b0, 1'b1, 15, 15);
      tick(1'b0, 1'b0, 1'b1, 16, 0);

      random_px(300, 80);
      set_thresh(0);
      random_px(150, 70);
      set_thresh(255);
      random_px(150, 90);
      set_thresh(int'($urandom_range(100, 240)));
      random_px(300, 75);

      // Async reset mid-line with de=1 traffic, outputs must drop before the next edge.
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, 160, 120);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      oq.delete();
      aq.delete();
      #1;
      check_all_zero("async_rst");
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst_hold");

      release_reset();
      drive(1'b0, 1'b0, 1'b1, 160, 120);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 160, 120);
      random_px(100, 100);
      tick(1'b0, 1'b0, 1'b0, 0, 0);

      for (int i = 0; i < 50 && (oq.size() > 0 || aq.size() > 0); i++) @(posedge clk);
      #1;
      chk("drain", oq.size() + aq.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
